ov7670_sccb_config: RTL and testbench
=====================================

// Module: ov7670_sccb_config
// PURPOSE
//  Boot-time register loader for the OV7670 sensor feeding camera_read: walks a register table and
//  issues one SCCB 3-phase write (ID, sub-address, data) per entry over open-drain SIOC/SIOD.
//  It must finish before pixel capture is trusted. Write-only; the ACK/don't-care bit is ignored.
//  The table is external (combinational ROM on cfg_addr/cfg_data), so contents change without RTL edits.
// PARAMETERS
//  CLK_DIV      25      clk cycles per SCCB quarter-bit Q; SCL period = 4*Q. Must be >= 2.
//  POWERUP_WAIT 1000000 clk cycles of bus idle after start, before the first write.
//  DELAY_CYCLES 500000  clk cycles inserted for each delay entry in the table.
//  WRITE_ID     8'h42   SCCB write slave ID; sent MSB first.
//  ADDR_W       8       width of cfg_addr; table holds at most 2**ADDR_W entries.
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       1-cycle pulse; begins the sequence from entry 0
//  cfg_addr   out  ADDR_W  table index; registered
//  cfg_data   in   16      {reg,val} at cfg_addr, valid the same cycle (combinational ROM)
//  sioc       out  1       SCCB clock, push-pull
//  siod_oe    out  1       1 = pull SIOD low, 0 = release (pad drives 0 when oe, else Z)
//  busy       out  1       high from accepted start until done rises
//  done       out  1       level; high after the terminator, cleared by the next accepted start
// BEHAVIOUR
//  Reset values: sioc=1, siod_oe=0, busy=0, done=0, cfg_addr=0. Reset is async: assertion mid-write
//   releases the bus and returns to IDLE at once, with no STOP sent.
//  States: IDLE -> PWRUP -> FETCH -> START -> BITS -> STOP -> GAP -> FETCH ... -> DONE; FETCH -> DLY -> FETCH.
//  IDLE/DONE: bus idle (sioc=1, siod_oe=0). start accepted only here. start while busy is ignored.
//   On accept: busy=1, done=0, cfg_addr=0, go to PWRUP.
//  PWRUP: count POWERUP_WAIT cycles with the bus idle, then FETCH.
//  FETCH: 1 cycle; decode cfg_data.
//   16'hFFFF -> DONE: busy=0, done=1.
//   16'hFFF0 -> DLY: count DELAY_CYCLES with the bus idle, then cfg_addr+1 and FETCH.
//   Otherwise: latch {ID,reg,val} into a 27-bit shift register; 9th bit of each byte is don't-care.
//  START: siod_oe=1 with sioc=1 for 2Q, then BITS.
//  BITS: 27 bit slots of 4Q each. Quarters 0-1: sioc=0. Quarters 2-3: sioc=1.
//   siod_oe=~bit, updated only at the start of quarter 0, so SIOD never changes while sioc=1.
//   Bit slots 8, 17 and 26 (the ACK/don't-care slots): siod_oe=0.
//  STOP: quarter 0: sioc=0, oe=1. Quarter 1: sioc=1, oe=1. Quarters 2-3: sioc=1, oe=0.
//  GAP: bus idle for 4Q; then cfg_addr+1 and FETCH.
//  Timing per write: 1 + (2+108+4+4)*Q clk cycles, from FETCH entry to the next FETCH.
//  Address wrap: if cfg_addr = 2**ADDR_W-1 completes without a terminator, go to DONE (no wrap to 0).
//  Simultaneous events: start arriving in the same cycle the sequence reaches DONE is ignored.
//   done stays 1; a later start re-runs the sequence.
//  Counters: all widths sized by $clog2 of their max parameter. No silent overflow is permitted.
// TESTING  (CLK_DIV=2, POWERUP_WAIT=10, DELAY_CYCLES=20, ADDR_W=4)
//  Table {1280,FFF0,1140,FFFF}, start pulse ->
//   write 1: bytes 42,12,80; then 20 idle cycles; then write 2: bytes 42,11,40.
//   Then done=1 and busy=0, with cfg_addr=3.
//  Bus monitor on every write -> siod_oe never toggles while sioc=1, except START and STOP.
//   SCL high time = 4 clk; oe=0 in every 9th slot.
//  Single write, from FETCH entry -> the next FETCH occurs exactly 1+118*2=237 cycles later.
//  rst_n low during bit 5 of the reg byte -> same cycle: sioc=1, oe=0, busy=0.
//   After release, no bus activity until start.
//  start pulsed again mid-sequence -> ignored: entry order and cfg_addr are unchanged.
//  Table with no FFFF (16 normal entries) -> 16 writes, then done=1. cfg_addr never returns to 0.

Source files
------------

// File: rtl/ov7670_sccb_config.sv
// OV7670 boot-time register loader: walks an external {reg,val} table and issues one
// SCCB 3-phase write (ID, sub-address, data) per entry on SIOC / open-drain SIOD.
module ov7670_sccb_config #(
  parameter int unsigned CLK_DIV      = 25,
  parameter int unsigned POWERUP_WAIT = 1000000,
  parameter int unsigned DELAY_CYCLES = 500000,
  parameter logic [7:0]  WRITE_ID     = 8'h42,
  parameter int unsigned ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] cfg_addr,
  input  logic [15:0]       cfg_data,
  output logic              sioc,
  output logic              siod_oe,
  output logic              busy,
  output logic              done
);
  localparam int unsigned QW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PWR_N    = (POWERUP_WAIT > 0) ? POWERUP_WAIT : 1;
  localparam int unsigned DLY_N    = (DELAY_CYCLES > 0) ? DELAY_CYCLES : 1;
  localparam int unsigned WAIT_MAX = (PWR_N > DLY_N) ? PWR_N : DLY_N;
  localparam int unsigned WW       = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  localparam logic [QW-1:0]     Q_LAST    = QW'(CLK_DIV - 1);
  localparam logic [WW-1:0]     PWR_LAST  = WW'(PWR_N - 1);
  localparam logic [WW-1:0]     DLY_LAST  = WW'(DLY_N - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [15:0]       TBL_END   = 16'hFFFF;
  localparam logic [15:0]       TBL_DELAY = 16'hFFF0;

  typedef enum logic [3:0] {
    S_IDLE, S_PWRUP, S_FETCH, S_START, S_BITS, S_STOP, S_GAP, S_DLY, S_DONE
  } state_t;

  state_t            state_r, state_s;
  logic [QW-1:0]     q_cnt_r, q_cnt_s;
  logic [1:0]        qtr_r, qtr_s;
  logic [4:0]        bit_r, bit_s;
  logic [WW-1:0]     wait_r, wait_s;
  logic [26:0]       shift_r, shift_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              sioc_r, sioc_s;
  logic              oe_r, oe_s;
  logic              q_tick_s, slot_end_s, ack_slot_s;

  // Next-state, counter and bus decode; bus outputs are registered one cycle behind the state.
  always_comb begin
    state_s    = state_r;
    q_cnt_s    = q_cnt_r;
    qtr_s      = qtr_r;
    bit_s      = bit_r;
    wait_s     = wait_r;
    shift_s    = shift_r;
    addr_s     = addr_r;
    busy_s     = busy_r;
    done_s     = done_r;
    sioc_s     = 1'b1;
    oe_s       = 1'b0;
    q_tick_s   = (q_cnt_r == Q_LAST);
    slot_end_s = q_tick_s && (qtr_r == 2'd3);
    ack_slot_s = (bit_r == 5'd8) || (bit_r == 5'd17) || (bit_r == 5'd26);

    if (q_tick_s) begin
      q_cnt_s = {QW{1'b0}};
      qtr_s   = qtr_r + 2'd1;
    end else begin
      q_cnt_s = q_cnt_r + QW'(1'b1);
      qtr_s   = qtr_r;
    end

    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_s = S_PWRUP;
          busy_s  = 1'b1;
          done_s  = 1'b0;
          addr_s  = {ADDR_W{1'b0}};
          wait_s  = {WW{1'b0}};
        end else begin
          state_s = state_r;
        end
      end
      S_PWRUP: begin
        if (wait_r == PWR_LAST) begin
          state_s = S_FETCH;
        end else begin
          wait_s = wait_r + WW'(1'b1);
        end
      end
      S_FETCH: begin
        q_cnt_s = {QW{1'b0}};
        qtr_s   = 2'd0;
        bit_s   = 5'd0;
        wait_s  = {WW{1'b0}};
        if (cfg_data == TBL_END) begin
          state_s = S_DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end else if (cfg_data == TBL_DELAY) begin
          state_s = S_DLY;
        end else begin
          // Don't-care slots are loaded as 1 so the released bus is the natural value.
          shift_s = {WRITE_ID, 1'b1, cfg_data[15:8], 1'b1, cfg_data[7:0], 1'b1};
          state_s = S_START;
        end
      end
      S_START: begin
        oe_s = 1'b1;
        if (q_tick_s && (qtr_r == 2'd1)) begin
          qtr_s   = 2'd0;
          state_s = S_BITS;
        end else begin
          state_s = S_START;
        end
      end
      S_BITS: begin
        sioc_s = qtr_r[1];
        oe_s   = ack_slot_s ? 1'b0 : ~shift_r[26];
        if (slot_end_s) begin
          shift_s = {shift_r[25:0], 1'b1};
          if (bit_r == 5'd26) begin
            state_s = S_STOP;
          end else begin
            bit_s = bit_r + 5'd1;
          end
        end else begin
          state_s = S_BITS;
        end
      end
      S_STOP: begin
        sioc_s = (qtr_r != 2'd0);
        oe_s   = ~qtr_r[1];
        if (slot_end_s) begin
          state_s = S_GAP;
        end else begin
          state_s = S_STOP;
        end
      end
      S_GAP: begin
        if (slot_end_s) begin
          if (addr_r == ADDR_LAST) begin
            state_s = S_DONE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            addr_s  = addr_r + ADDR_W'(1'b1);
            state_s = S_FETCH;
          end
        end else begin
          state_s = S_GAP;
        end
      end
      S_DLY: begin
        if (wait_r == DLY_LAST) begin
          if (addr_r == ADDR_LAST) begin
            state_s = S_DONE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            addr_s  = addr_r + ADDR_W'(1'b1);
            state_s = S_FETCH;
          end
        end else begin
          wait_s = wait_r + WW'(1'b1);
        end
      end
      default: begin
        state_s = S_IDLE;
        busy_s  = 1'b0;
        done_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset releases the bus immediately, no STOP is sent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      q_cnt_r <= {QW{1'b0}};
      qtr_r   <= 2'd0;
      bit_r   <= 5'd0;
      wait_r  <= {WW{1'b0}};
      shift_r <= 27'd0;
      addr_r  <= {ADDR_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sioc_r  <= 1'b1;
      oe_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      q_cnt_r <= q_cnt_s;
      qtr_r   <= qtr_s;
      bit_r   <= bit_s;
      wait_r  <= wait_s;
      shift_r <= shift_s;
      addr_r  <= addr_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      sioc_r  <= sioc_s;
      oe_r    <= oe_s;
    end
  end

  assign cfg_addr = addr_r;
  assign sioc     = sioc_r;
  assign siod_oe  = oe_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// Bench for ov7670_sccb_config: a bus decoder reconstructs each SCCB write and compares it
// with a queue of writes predicted from the table contents.
module tb_ov7670_sccb_config;
  localparam int CLK_DIV      = 2;
  localparam int POWERUP_WAIT = 10;
  localparam int DELAY_CYCLES = 20;
  localparam int ADDR_W       = 4;
  localparam int N_ENT        = 1 << ADDR_W;
  localparam int WRITE_CYC    = 1 + (2 + 27 * 4 + 4 + 4) * CLK_DIV;
  localparam int DELAY_CYC    = 1 + DELAY_CYCLES;

  typedef struct {
    logic [23:0] bytes;
    int          gap;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] cfg_addr;
  logic [15:0]       cfg_data;
  logic              sioc, siod_oe, busy, done;

  logic [15:0] rom [N_ENT];
  exp_t        exp_q[$];
  int          exp_addr;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          bus_events = 0;

  logic              m_ps, m_po, m_pb, m_in_frame, m_seen_rise;
  logic [ADDR_W-1:0] m_pa;
  logic [26:0]       m_frame;
  int                m_nbits, m_hc, m_start_cyc, m_last_start;
  exp_t              m_e;

  assign cfg_data = rom[cfg_addr];

  ov7670_sccb_config #(
    .CLK_DIV(CLK_DIV), .POWERUP_WAIT(POWERUP_WAIT), .DELAY_CYCLES(DELAY_CYCLES),
    .WRITE_ID(8'h42), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .sioc(sioc), .siod_oe(siod_oe), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: one write per ordinary entry, delays only stretch the spacing.
  task automatic build_expect();
    int   pend  = 0;
    bit   first = 1'b1;
    exp_t e;
    exp_q.delete();
    exp_addr = N_ENT - 1;
    for (int i = 0; i < N_ENT; i++) begin
      if (rom[i] == 16'hFFFF) begin
        exp_addr = i;
        break;
      end else if (rom[i] == 16'hFFF0) begin
        pend++;
      end else begin
        e.bytes = {8'h42, rom[i]};
        e.gap   = first ? -1 : WRITE_CYC + pend * DELAY_CYC;
        exp_q.push_back(e);
        first = 1'b0;
        pend  = 0;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_within_budget", done, 1);
  endtask

  task automatic run_table(input bit mid_pulse);
    build_expect();
    pulse_start();
    if (mid_pulse) begin
      repeat (150) @(negedge clk);
      pulse_start();
      check("busy_after_ignored_start", busy, 1);
      check("done_after_ignored_start", done, 0);
    end
    wait_done(20000);
    check("final_busy", busy, 0);
    check("final_addr", cfg_addr, exp_addr);
    check("writes_outstanding", exp_q.size(), 0);
  endtask

  task automatic fill_random(input bit allow_special);
    int          sel;
    logic [15:0] v;
    for (int i = 0; i < N_ENT; i++) begin
      sel = allow_special ? $urandom_range(0, 11) : 11;
      v   = 16'($urandom());
      if (v == 16'hFFFF || v == 16'hFFF0) v = 16'h1234;
      if (sel == 0)      rom[i] = 16'hFFF0;
      else if (sel == 1) rom[i] = 16'hFFFF;
      else               rom[i] = v;
    end
  endtask

  // Bus decoder / scoreboard checker, sampling on the falling edge.
  initial begin
    m_in_frame = 1'b0;
    m_nbits    = 0;
    m_last_start = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        m_ps = 1'b1; m_po = 1'b0; m_pb = 1'b0; m_pa = '0;
        m_in_frame = 1'b0; m_nbits = 0; m_seen_rise = 1'b0;
      end else begin
        if (sioc !== m_ps || siod_oe !== m_po) bus_events++;
        if (m_ps && sioc && !m_po && siod_oe) begin
          check("start_outside_frame", m_in_frame, 0);
          m_in_frame = 1'b1; m_nbits = 0; m_seen_rise = 1'b0;
          m_frame = '0; m_start_cyc = cyc;
        end else if (m_ps && sioc && m_po && !siod_oe) begin
          check("stop_inside_frame", m_in_frame, 1);
          check("bits_per_write", m_nbits, 27);
          check("ack_slots_released", {m_frame[18], m_frame[9], m_frame[0]}, 3'b111);
          check("write_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            check("write_bytes", {m_frame[26:19], m_frame[17:10], m_frame[8:1]}, m_e.bytes);
            if (m_e.gap >= 0) check("write_spacing", m_start_cyc - m_last_start, m_e.gap);
            m_last_start = m_start_cyc;
          end
          m_in_frame = 1'b0; m_seen_rise = 1'b0;
        end else if (!m_ps && sioc && m_in_frame) begin
          if (m_nbits < 27) begin
            m_frame = {m_frame[25:0], ~siod_oe};
            m_nbits++;
            m_seen_rise = 1'b1;
            m_hc = 1;
          end else begin
            m_seen_rise = 1'b0;
          end
        end else if (m_ps && sioc && m_in_frame && m_seen_rise) begin
          m_hc++;
        end else if (m_ps && !sioc && m_in_frame && m_seen_rise) begin
          check("scl_high_clk", m_hc, 4);
        end
        if (busy && m_pb && cfg_addr !== m_pa) check("addr_step", cfg_addr, m_pa + 1);
        m_ps = sioc; m_po = siod_oe; m_pb = busy; m_pa = cfg_addr;
      end
    end
  end

  initial begin
    int k;
    int ev;
    rst_n = 1'b1;
    start = 1'b0;
    for (int i = 0; i < N_ENT; i++) rom[i] = 16'hFFFF;
    #2 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_sioc", sioc, 1);
    check("reset_oe", siod_oe, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_addr", cfg_addr, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_before_start", bus_events, 0);

    rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1140; rom[3] = 16'hFFFF;
    run_table(1'b1);
    run_table(1'b0);

    fill_random(1'b0);
    run_table(1'b0);
    for (int t = 0; t < 4; t++) begin
      fill_random(1'b1);
      run_table(1'b0);
    end

    for (int i = 0; i < N_ENT; i++) rom[i] = 16'hFFFF;
    rom[0] = 16'h3A04; rom[1] = 16'h4010;
    build_expect();
    pulse_start();
    k = 0;
    while (!(m_in_frame && m_nbits == 15) && k < 5000) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("reached_reg_bit5", m_nbits, 15);
    rst_n = 1'b0;
    #1;
    check("rst_mid_sioc", sioc, 1);
    check("rst_mid_oe", siod_oe, 0);
    check("rst_mid_busy", busy, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    ev = bus_events;
    repeat (300) @(negedge clk);
    #1;
    check("idle_after_reset", bus_events - ev, 0);
    check("busy_after_reset", busy, 0);
    check("done_after_reset", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
